// File: rtl/get_nbrs_address_pkg.sv
// ---------------------------------------------------------------------------
// get_nbrs_address_pkg
// Shared definitions for the Game-of-Life neighbour addressing logic.
//   NEIGHBOURS_CNT : number of Moore neighbours of a cell (8)
//   NBR_DX/NBR_DY  : column/row offset of each neighbour index, y grows
//                    downward. The neighbour counter uses the same tables, so
//                    index k means the same cell on both sides.
//   in_field()     : range test done at full integer width
// ---------------------------------------------------------------------------
package get_nbrs_address_pkg;

    localparam int NEIGHBOURS_CNT = 8;

    // Index map:  0 1 2
    //             3 . 4
    //             5 6 7
    localparam int NBR_DX [NEIGHBOURS_CNT] = '{-1,  0, +1, -1, +1, -1,  0, +1};
    localparam int NBR_DY [NEIGHBOURS_CNT] = '{-1, -1, -1,  0,  0, +1, +1, +1};

    // True when pos is a legal coordinate along an axis of 'size' cells.
    // Both operands are full-width ints, so a -1 offset from 0 stays negative
    // here instead of wrapping to the top of the address range.
    function automatic logic in_field(input int pos, input int size);
        return (pos >= 0) && (pos < size);
    endfunction

endpackage : get_nbrs_address_pkg

// File: rtl/get_nbrs_address_if.sv
// ---------------------------------------------------------------------------
// get_nbrs_address_if
// Bundle between a cell-address source and the neighbour address generator.
//   i_cell_x_adr / i_cell_y_adr : centre cell column / row
//   o_nbrs_x_adr / o_nbrs_y_adr : per-neighbour column / row (index 0..7)
//   o_nbrs_rlvnt                : per-neighbour "inside the field" flag
// Modports:
//   master : the cell-update engine (drives the centre, reads neighbours)
//   slave  : get_nbrs_address
// ---------------------------------------------------------------------------
interface get_nbrs_address_if #(
    parameter int FIELD_W = 4,
    parameter int FIELD_H = 3
);
    import get_nbrs_address_pkg::*;

    localparam int X_ADR_SIZE = $clog2(FIELD_W);
    localparam int Y_ADR_SIZE = $clog2(FIELD_H);

    logic [X_ADR_SIZE-1:0]                     i_cell_x_adr;
    logic [Y_ADR_SIZE-1:0]                     i_cell_y_adr;
    logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] o_nbrs_x_adr;
    logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] o_nbrs_y_adr;
    logic [NEIGHBOURS_CNT-1:0]                 o_nbrs_rlvnt;

    modport master (
        output i_cell_x_adr, i_cell_y_adr,
        input  o_nbrs_x_adr, o_nbrs_y_adr, o_nbrs_rlvnt
    );

    modport slave (
        input  i_cell_x_adr, i_cell_y_adr,
        output o_nbrs_x_adr, o_nbrs_y_adr, o_nbrs_rlvnt
    );

endinterface : get_nbrs_address_if

// File: rtl/get_nbrs_address_nbr_offset_calc.sv
// ---------------------------------------------------------------------------
// nbr_offset_calc
// Combinational address and relevance of one neighbour at a fixed offset
// (DX, DY) from the centre cell.
//   cell_x_adr / cell_y_adr : centre cell
//   nbr_x_adr  / nbr_y_adr  : centre + offset, modulo 2^width
//   nbr_rlvnt               : 1 when both the centre and the neighbour lie
//                             inside the FIELD_W x FIELD_H field
// ---------------------------------------------------------------------------
module nbr_offset_calc
    import get_nbrs_address_pkg::*;
#(
    parameter int FIELD_W = 4,
    parameter int FIELD_H = 3,
    parameter int DX      = 0,
    parameter int DY      = 0
) (
    input  logic [$clog2(FIELD_W)-1:0] cell_x_adr,
    input  logic [$clog2(FIELD_H)-1:0] cell_y_adr,
    output logic [$clog2(FIELD_W)-1:0] nbr_x_adr,
    output logic [$clog2(FIELD_H)-1:0] nbr_y_adr,
    output logic                       nbr_rlvnt
);

    localparam int X_ADR_SIZE = $clog2(FIELD_W);
    localparam int Y_ADR_SIZE = $clog2(FIELD_H);

    int x_full;
    int y_full;

    // Truncating the offset to the address width makes -1 an all-ones
    // addend, so the sum wraps modulo 2^width as consumers expect.
    assign nbr_x_adr = cell_x_adr + X_ADR_SIZE'(DX);
    assign nbr_y_adr = cell_y_adr + Y_ADR_SIZE'(DY);

    always_comb begin
        // NOTE: every variable assigned here gets a value on every pass through
        // the block; a path that skips an assignment would infer a latch.
        x_full    = int'(cell_x_adr) + DX;
        y_full    = int'(cell_y_adr) + DY;
        // A centre outside the field (non-power-of-2 sizes) has no relevant
        // neighbours, even if some neighbour coordinate lands inside.
        nbr_rlvnt = in_field(int'(cell_x_adr), FIELD_W) &&
                    in_field(int'(cell_y_adr), FIELD_H) &&
                    in_field(x_full, FIELD_W) &&
                    in_field(y_full, FIELD_H);
    end

endmodule : nbr_offset_calc

// File: rtl/get_nbrs_address.sv
// ---------------------------------------------------------------------------
// get_nbrs_address
// Addresses of the 8 Moore neighbours of one cell of a FIELD_W x FIELD_H
// Game-of-Life field, each flagged relevant only when it is inside the field
// (no toroidal wrap). One register stage: the cell presented before a rising
// edge appears on the outputs after that edge; a new cell may be presented
// every cycle.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset, clears all outputs
//   bus     : get_nbrs_address_if.slave (centre cell in, neighbours out)
// ---------------------------------------------------------------------------
module get_nbrs_address
    import get_nbrs_address_pkg::*;
#(
    parameter int FIELD_W = 4,
    parameter int FIELD_H = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    get_nbrs_address_if.slave   bus
);

    localparam int X_ADR_SIZE = $clog2(FIELD_W);
    localparam int Y_ADR_SIZE = $clog2(FIELD_H);

    logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] nbrs_x_comb;
    logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] nbrs_y_comb;
    logic [NEIGHBOURS_CNT-1:0]                 nbrs_rlvnt_comb;

    for (genvar k = 0; k < NEIGHBOURS_CNT; k++) begin : g_nbr
        nbr_offset_calc #(
            .FIELD_W (FIELD_W),
            .FIELD_H (FIELD_H),
            .DX      (NBR_DX[k]),
            .DY      (NBR_DY[k])
        ) u_nbr_offset_calc (
            .cell_x_adr (bus.i_cell_x_adr),
            .cell_y_adr (bus.i_cell_y_adr),
            .nbr_x_adr  (nbrs_x_comb[k]),
            .nbr_y_adr  (nbrs_y_comb[k]),
            .nbr_rlvnt  (nbrs_rlvnt_comb[k])
        );
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    // NOTE: these are a handful of flops, not a memory, so all of them are
    // reset; consumers see clean zeros the moment reset is asserted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_nbrs_x_adr <= '0;
            bus.o_nbrs_y_adr <= '0;
            bus.o_nbrs_rlvnt <= '0;
        end else begin
            bus.o_nbrs_x_adr <= nbrs_x_comb;
            bus.o_nbrs_y_adr <= nbrs_y_comb;
            bus.o_nbrs_rlvnt <= nbrs_rlvnt_comb;
        end
    end

endmodule : get_nbrs_address

// File: tb/tb_get_nbrs_address.sv
// ---------------------------------------------------------------------------
// tb_get_nbrs_address
// Two instances (4x3 and 5x5 fields) share one clock and reset. Every cycle a
// new centre cell is driven into each; the next cycle's outputs are compared
// against a reference model that walks the 3x3 window around the centre.
// ---------------------------------------------------------------------------
module tb_get_nbrs_address;

    logic i_clk;
    logic i_rst_n;

    get_nbrs_address_if #(.FIELD_W(4), .FIELD_H(3)) if_a ();
    get_nbrs_address_if #(.FIELD_W(5), .FIELD_H(5)) if_b ();

    get_nbrs_address #(.FIELD_W(4), .FIELD_H(3)) u_dut_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (if_a.slave)
    );

    get_nbrs_address #(.FIELD_W(5), .FIELD_H(5)) u_dut_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (if_b.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Centre cells driven in the previous cycle; their results are due now.
    int  prev_ax, prev_ay, prev_bx, prev_by;
    bit  have_prev = 1'b0;

    task automatic check(input string tag, input int observed, input int expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: scan the 3x3 window row by row, skipping the centre; the
    // scan order is the neighbour numbering.
    task automatic model(input int w, input int h, input int xw, input int yw,
                         input int cx, input int cy,
                         output int ex[8], output int ey[8], output int er[8]);
        int k;
        k = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx != 0 || dy != 0) begin
                    ex[k] = (cx + dx) & ((1 << xw) - 1);
                    ey[k] = (cy + dy) & ((1 << yw) - 1);
                    er[k] = (cx < w && cy < h &&
                             cx + dx >= 0 && cx + dx < w &&
                             cy + dy >= 0 && cy + dy < h) ? 1 : 0;
                    k++;
                end
            end
        end
    endtask

    task automatic compare_dut(input string name, input int w, input int h,
                               input int xw, input int yw, input int cx, input int cy,
                               input int ox[8], input int oy[8], input int orl[8]);
        int ex[8], ey[8], er[8];
        model(w, h, xw, yw, cx, cy, ex, ey, er);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s c(%0d,%0d) n%0d x", name, cx, cy, k), ox[k], ex[k]);
            check($sformatf("%s c(%0d,%0d) n%0d y", name, cx, cy, k), oy[k], ey[k]);
            check($sformatf("%s c(%0d,%0d) n%0d rlvnt", name, cx, cy, k), orl[k], er[k]);
        end
    endtask

    task automatic compare_both();
        int ox[8], oy[8], orl[8];
        for (int k = 0; k < 8; k++) begin
            ox[k]  = int'(if_a.o_nbrs_x_adr[k]);
            oy[k]  = int'(if_a.o_nbrs_y_adr[k]);
            orl[k] = int'(if_a.o_nbrs_rlvnt[k]);
        end
        compare_dut("4x3", 4, 3, 2, 2, prev_ax, prev_ay, ox, oy, orl);
        for (int k = 0; k < 8; k++) begin
            ox[k]  = int'(if_b.o_nbrs_x_adr[k]);
            oy[k]  = int'(if_b.o_nbrs_y_adr[k]);
            orl[k] = int'(if_b.o_nbrs_rlvnt[k]);
        end
        compare_dut("5x5", 5, 5, 3, 3, prev_bx, prev_by, ox, oy, orl);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " 4x3 x"},     int'(if_a.o_nbrs_x_adr), 0);
        check({tag, " 4x3 y"},     int'(if_a.o_nbrs_y_adr), 0);
        check({tag, " 4x3 rlvnt"}, int'(if_a.o_nbrs_rlvnt), 0);
        check({tag, " 5x5 x"},     int'(if_b.o_nbrs_x_adr), 0);
        check({tag, " 5x5 y"},     int'(if_b.o_nbrs_y_adr), 0);
        check({tag, " 5x5 rlvnt"}, int'(if_b.o_nbrs_rlvnt), 0);
    endtask

    // One cycle: on the falling edge, check the result of the cell driven
    // last cycle, then drive the next cell.
    task automatic step(input int ax, input int ay, input int bx, input int by);
        @(negedge i_clk);
        if (have_prev) compare_both();
        if_a.i_cell_x_adr = 2'(ax);
        if_a.i_cell_y_adr = 2'(ay);
        if_b.i_cell_x_adr = 3'(bx);
        if_b.i_cell_y_adr = 3'(by);
        prev_ax = ax; prev_ay = ay; prev_bx = bx; prev_by = by;
        have_prev = 1'b1;
    endtask

    task automatic step_random();
        step($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 7), $urandom_range(0, 7));
    endtask

    initial begin
        // Reset with arbitrary inputs applied.
        i_rst_n = 1'b0;
        if_a.i_cell_x_adr = 2'd3;
        if_a.i_cell_y_adr = 2'd2;
        if_b.i_cell_x_adr = 3'd4;
        if_b.i_cell_y_adr = 3'd1;
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");

        i_rst_n = 1'b1;
        // Directed cells: interior, corners, edges.
        step(1, 1, 1, 1);
        step(0, 0, 0, 0);
        step(3, 2, 4, 4);
        step(1, 0, 2, 0);
        step(3, 1, 4, 2);
        step(0, 2, 0, 4);

        // Full sweep of both fields, back to back.
        for (int i = 0; i < 25; i++)
            step((i % 12) % 4, (i % 12) / 4, i % 5, i / 5);

        // Centres outside the field.
        step(2, 3, 5, 0);
        step(0, 3, 5, 2);
        step(3, 3, 7, 7);
        step(1, 1, 2, 6);

        repeat (150) step_random();

        // Reset asserted mid-stream, away from any clock edge.
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 check_all_zero("mid-reset");
        have_prev = 1'b0;
        @(negedge i_clk);
        check_all_zero("mid-reset held");
        i_rst_n = 1'b1;
        step(1, 1, 3, 3);

        repeat (40) step_random();
        @(negedge i_clk);
        compare_both();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_get_nbrs_address
